// File: rtl/ram_2p_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_pkg (package)
//  Purpose  : Shared types, constants and the byte-lane merge helper for the
//             ram_2p dual-port RAM.
//  Contents : ram_state_t     - clear-sequencer states
//             DEFAULT_BYTE_W  - default byte-enable lane width
//             byte_merge()    - lane-merges a new word over an old word
//  Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int unsigned DEFAULT_BYTE_W = 8;

  // byte_merge works on a fixed maximum word so that a single function can
  // serve every instance width. Callers zero-extend their operands and
  // truncate the result. Supported range: WIDTH <= 256, NB <= 64.
  localparam int unsigned MERGE_MAX_W  = 256;
  localparam int unsigned MERGE_MAX_NB = 64;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  // Lanes with be[i]=1 come from new_word, every other bit keeps old_word.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_NB-1:0] be,
    input int unsigned             byte_w
  );
    logic [MERGE_MAX_W-1:0] lane;
    logic [MERGE_MAX_W-1:0] mask;
    lane = (MERGE_MAX_W'(1) << byte_w) - MERGE_MAX_W'(1);
    mask = '0;
    for (int i = 0; i < MERGE_MAX_NB; i++) begin
      if (be[i]) begin
        mask = mask | (lane << (i * byte_w));
      end
    end
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_2p_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_2p_if (interface)
//  Purpose  : Groups the clear/write/read port signals of ram_2p.
//  Ports    : init, busy                 - clear request / sweep in progress
//             we, wbe, waddr, wdata      - write port with byte enables
//             re, raddr, rdata, rvalid   - read port
//  Modports : master (requester side), slave (RAM side)
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_2p_if
  import ram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int BYTE_W = DEFAULT_BYTE_W
);
  localparam int NB = WIDTH / BYTE_W;
  localparam int AW = $clog2(DEPTH);

  logic             init;
  logic             busy;
  logic             we;
  logic [NB-1:0]    wbe;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;

  modport master (
    output init, we, wbe, waddr, wdata, re, raddr,
    input  busy, rdata, rvalid
  );

  modport slave (
    input  init, we, wbe, waddr, wdata, re, raddr,
    output busy, rdata, rvalid
  );

endinterface : ram_2p_if
`default_nettype wire

// File: rtl/ram_2p_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_clear_ctrl
//  Purpose  : Clear sequencer for ram_2p. After reset or an init request it
//             sweeps the array one word per cycle, writing zero, then hands
//             the array over to the user ports.
//  Ports    : clk, rst   - clock, asynchronous active-high reset
//             init       - clear request (honoured only in ST_READY)
//             busy       - registered, high while sweeping
//             clr_we     - clear write strobe for the array
//             clr_addr   - clear write address (sweep counter)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          init,
  output logic               busy,
  output logic               clr_we,
  output logic [AW-1:0]      clr_addr
);

  localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

  ram_state_t    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // The word at r_cnt is zeroed on this edge; leave once the last
          // word has been written.
          if (r_cnt == c_last) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (init) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign clr_we   = (r_state == ST_CLEAR);
  assign clr_addr = r_cnt;

endmodule : ram_clear_ctrl
`default_nettype wire

// File: rtl/ram_2p.sv
`default_nettype none
// ============================================================================
//  Module   : ram_2p
//  Purpose  : Simple dual-port synchronous RAM (one write, one read port)
//             with per-byte write enables, write-first same-address
//             forwarding, a read-valid flag and a hardware clear sweep.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - ram_2p_if.slave: init/busy, write port, read port
//  Config   : RAM_OUTREG_EN - when defined, adds an output register after
//             the read mux (read latency 2 instead of 1).
//  Revision : 1.0 - initial release
// ============================================================================
module ram_2p
  import ram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int BYTE_W = DEFAULT_BYTE_W
) (
  input  wire logic clk,
  input  wire logic rst,
  ram_2p_if.slave   bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_busy;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_accept;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_fwd;
  logic [WIDTH-1:0] w_wr_word;
  logic [WIDTH-1:0] w_rd_word;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;

  ram_clear_ctrl #(
    .DEPTH (DEPTH)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .init     (bus.init),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign bus.busy = w_busy;

  // A cycle carrying init is swallowed entirely, as is every cycle of a sweep.
  assign w_accept      = ~w_busy & ~bus.init;
  assign w_wr_in_range = ({1'b0, bus.waddr} < c_depth);
  assign w_rd_in_range = ({1'b0, bus.raddr} < c_depth);
  assign w_wr_acc      = w_accept & bus.we & w_wr_in_range;
  assign w_rd_acc      = w_accept & bus.re;
  assign w_fwd         = w_wr_acc & (bus.waddr == bus.raddr);

  // Merged word for the write; reused as the forwarded read value, since
  // on a same-address hit the old word is the same array entry.
  assign w_wr_word = WIDTH'(byte_merge(MERGE_MAX_W'(r_mem[bus.waddr]),
                                       MERGE_MAX_W'(bus.wdata),
                                       MERGE_MAX_NB'(bus.wbe),
                                       BYTE_W));

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = w_fwd ? w_wr_word : r_mem[bus.raddr];
    end
  end

  // Array storage carries no reset; the clear sweep owns initialisation.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[bus.waddr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= w_rd_word;
      end
    end
  end

`ifdef RAM_OUTREG_EN
  logic [WIDTH-1:0] r_rdata_q;
  logic             r_rvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_q  <= '0;
      r_rvalid_q <= 1'b0;
    end else begin
      r_rdata_q  <= r_rdata;
      r_rvalid_q <= r_rvalid;
    end
  end

  assign bus.rdata  = r_rdata_q;
  assign bus.rvalid = r_rvalid_q;
`else
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
`endif

endmodule : ram_2p
`default_nettype wire

// File: tb/tb_ram_2p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_2p
//  Purpose  : Self-checking bench for ram_2p. Two instances: DEPTH=16 and
//             DEPTH=12 (non power of two, for out-of-range handling).
//             Honours RAM_OUTREG_EN for the expected read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_2p;

`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  ram_2p_if #(.WIDTH(32), .DEPTH(16), .BYTE_W(8)) b16 ();
  ram_2p_if #(.WIDTH(32), .DEPTH(12), .BYTE_W(8)) b12 ();

  ram_2p #(.WIDTH(32), .DEPTH(16), .BYTE_W(8)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  ram_2p #(.WIDTH(32), .DEPTH(12), .BYTE_W(8)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (b12)
  );

  // ---------------- read scoreboards ----------------
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q16[$];
  exp_t q12[$];
  exp_t e16;
  exp_t e12;

  always @(negedge clk) begin
    if (b16.rvalid) begin
      n_tests++;
      if (q16.size() == 0) begin
        n_fail++;
        $display("FAIL rd16_unexpected: rvalid=1 rdata=%h at cycle %0d, required no read outstanding",
                 b16.rdata, cyc);
      end else begin
        e16 = q16.pop_front();
        if (b16.rdata !== e16.data || cyc != e16.due) begin
          n_fail++;
          $display("FAIL rd16: rdata=%h at cycle %0d, required %h at cycle %0d",
                   b16.rdata, cyc, e16.data, e16.due);
        end
      end
    end else if (q16.size() != 0 && q16[0].due <= cyc) begin
      n_tests++;
      n_fail++;
      e16 = q16.pop_front();
      $display("FAIL rd16_missing: rvalid=0 at cycle %0d, required rdata=%h", cyc, e16.data);
    end
  end

  always @(negedge clk) begin
    if (b12.rvalid) begin
      n_tests++;
      if (q12.size() == 0) begin
        n_fail++;
        $display("FAIL rd12_unexpected: rvalid=1 rdata=%h at cycle %0d, required no read outstanding",
                 b12.rdata, cyc);
      end else begin
        e12 = q12.pop_front();
        if (b12.rdata !== e12.data || cyc != e12.due) begin
          n_fail++;
          $display("FAIL rd12: rdata=%h at cycle %0d, required %h at cycle %0d",
                   b12.rdata, cyc, e12.data, e12.due);
        end
      end
    end else if (q12.size() != 0 && q12[0].due <= cyc) begin
      n_tests++;
      n_fail++;
      e12 = q12.pop_front();
      $display("FAIL rd12_missing: rvalid=0 at cycle %0d, required rdata=%h", cyc, e12.data);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic wr16(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    b16.we = 1'b1; b16.wbe = be; b16.waddr = a; b16.wdata = d;
    step();
    b16.we = 1'b0;
  endtask

  task automatic rd16(input logic [3:0] a, input logic [31:0] req);
    b16.re = 1'b1; b16.raddr = a;
    q16.push_back('{req, cyc + LAT});
    step();
    b16.re = 1'b0;
  endtask

  task automatic wr12(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    b12.we = 1'b1; b12.wbe = be; b12.waddr = a; b12.wdata = d;
    step();
    b12.we = 1'b0;
  endtask

  task automatic rd12(input logic [3:0] a, input logic [31:0] req);
    b12.re = 1'b1; b12.raddr = a;
    q12.push_back('{req, cyc + LAT});
    step();
    b12.re = 1'b0;
  endtask

  // Counts edges until busy is seen low on each instance (-1 on timeout).
  task automatic count_busy(output int c16, output int c12);
    c16 = -1;
    c12 = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (c16 < 0 && !b16.busy) c16 = k;
      if (c12 < 0 && !b12.busy) c12 = k;
      if (c16 >= 0 && c12 >= 0) break;
    end
  endtask

  task automatic drain();
    repeat (LAT + 2) step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  wbe;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];
  int   c16;
  int   c12;

  initial begin
    b16.init = 0; b16.we = 0; b16.wbe = '0; b16.waddr = '0; b16.wdata = '0;
    b16.re = 0; b16.raddr = '0;
    b12.init = 0; b12.we = 0; b12.wbe = '0; b12.waddr = '0; b12.wdata = '0;
    b12.re = 0; b12.raddr = '0;

    tbl[0]  = '{1'b1, 4'hF, 4'd3,  32'hAABBCCDD, 1'b0, 4'd0,  32'h0};
    tbl[1]  = '{1'b1, 4'h5, 4'd3,  32'h11223344, 1'b0, 4'd0,  32'h0};
    tbl[2]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd3,  32'hAA22CC44};
    tbl[3]  = '{1'b1, 4'hF, 4'd5,  32'hFFFFFFFF, 1'b0, 4'd0,  32'h0};
    tbl[4]  = '{1'b1, 4'h3, 4'd5,  32'h00001234, 1'b1, 4'd5,  32'hFFFF1234};
    tbl[5]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd5,  32'hFFFF1234};
    tbl[6]  = '{1'b1, 4'h0, 4'd5,  32'h00000000, 1'b1, 4'd5,  32'hFFFF1234};
    tbl[7]  = '{1'b1, 4'hF, 4'd0,  32'h12345678, 1'b1, 4'd15, 32'h0};
    tbl[8]  = '{1'b1, 4'hF, 4'd15, 32'hCAFEF00D, 1'b1, 4'd0,  32'h12345678};
    tbl[9]  = '{1'b1, 4'h8, 4'd15, 32'h55FFFFFF, 1'b1, 4'd15, 32'h55FEF00D};
    tbl[10] = '{1'b1, 4'hF, 4'd7,  32'h77777777, 1'b1, 4'd3,  32'hAA22CC44};
    tbl[11] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd7,  32'h77777777};
    tbl[12] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd15, 32'h55FEF00D};

    // ---- reset values and power-on sweep ----
    #1 rst = 1'b1;
    #1;
    chk("rst_busy16",   32'(b16.busy),   32'd1);
    chk("rst_rvalid16", 32'(b16.rvalid), 32'd0);
    chk("rst_rdata16",  b16.rdata,       32'd0);
    chk("rst_busy12",   32'(b12.busy),   32'd1);
    step();
    rst = 1'b0;
    // Stray accesses during the sweep must be ignored.
    b16.we = 1'b1; b16.wbe = 4'hF; b16.waddr = 4'd2; b16.wdata = 32'hEEEEEEEE;
    b16.re = 1'b1; b16.raddr = 4'd2;
    count_busy(c16, c12);
    b16.we = 1'b0; b16.re = 1'b0;
    chk("sweep16_edges", c16, 32'd16);
    chk("sweep12_edges", c12, 32'd12);
    for (int i = 0; i < 16; i++) rd16(4'(i), 32'h0);
    for (int i = 0; i < 12; i++) rd12(4'(i), 32'h0);
    drain();

    // ---- table-driven main function ----
    for (int i = 0; i < 13; i++) begin
      b16.we = tbl[i].we; b16.wbe = tbl[i].wbe; b16.waddr = tbl[i].waddr;
      b16.wdata = tbl[i].wdata; b16.re = tbl[i].re; b16.raddr = tbl[i].raddr;
      if (tbl[i].re) q16.push_back('{tbl[i].exp, cyc + LAT});
      step();
    end
    b16.we = 1'b0; b16.re = 1'b0;
    drain();

    // ---- init with ignored accesses ----
    wr16(4'd2, 4'hF, 32'h22222222);
    rd16(4'd2, 32'h22222222);
    b16.init = 1'b1;
    b16.we = 1'b1; b16.wbe = 4'hF; b16.waddr = 4'd4; b16.wdata = 32'h44444444;
    step();
    b16.init = 1'b0;
    chk("init_busy16", 32'(b16.busy), 32'd1);
    b16.waddr = 4'd2; b16.wdata = 32'hBBBBBBBB; b16.re = 1'b1; b16.raddr = 4'd2;
    count_busy(c16, c12);
    b16.we = 1'b0; b16.re = 1'b0;
    chk("init16_edges", c16, 32'd16);
    rd16(4'd2, 32'h0);
    rd16(4'd4, 32'h0);
    rd16(4'd3, 32'h0);
    rd16(4'd15, 32'h0);
    drain();

    // ---- out-of-range on the DEPTH=12 instance ----
    for (int i = 0; i < 12; i++) wr12(4'(i), 4'hF, 32'h10000000 + 32'(i));
    wr12(4'd13, 4'hF, 32'hDEADBEEF);
    wr12(4'd12, 4'hF, 32'hDEADBEEF);
    b12.we = 1'b1; b12.wbe = 4'hF; b12.waddr = 4'd13; b12.wdata = 32'hDEADBEEF;
    b12.re = 1'b1; b12.raddr = 4'd13;
    q12.push_back('{32'h0, cyc + LAT});
    step();
    b12.we = 1'b0; b12.re = 1'b0;
    rd12(4'd13, 32'h0);
    rd12(4'd15, 32'h0);
    for (int i = 0; i < 12; i++) rd12(4'(i), 32'h10000000 + 32'(i));
    drain();

    // ---- reset in the middle of a sweep ----
    wr16(4'd9, 4'hF, 32'h00000009);
    rd16(4'd9, 32'h00000009);
    drain();
    b16.init = 1'b1;
    step();
    b16.init = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    #1;
    chk("midrst_busy16",   32'(b16.busy),   32'd1);
    chk("midrst_rvalid16", 32'(b16.rvalid), 32'd0);
    chk("midrst_rdata16",  b16.rdata,       32'd0);
    chk("midrst_rdata12",  b12.rdata,       32'd0);
    step();
    step();
    rst = 1'b0;
    count_busy(c16, c12);
    chk("midrst16_edges", c16, 32'd16);
    chk("midrst12_edges", c12, 32'd12);
    rd16(4'd9, 32'h0);
    rd12(4'd11, 32'h0);
    drain();

    chk("q16_drained", q16.size(), 32'd0);
    chk("q12_drained", q12.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_2p
`default_nettype wire
